// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with a hold limit.
// Every release leaves one idle cycle before the next grant.
module rr_arb4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       preempt
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       gnt_id_nxt;
    logic             busy_nxt;
    logic             preempt_nxt;
    logic [1:0]       win;
    logic [3:0]       others;

    // First asserted requester searching last+1, last+2, last+3, last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] w;
        logic [1:0] idx;
        w = l;
        for (int i = 4; i >= 1; i--) begin
            idx = l + 2'(i);
            if (r[idx]) w = idx;
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 2'd3;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= gnt_id_nxt;
            busy    <= busy_nxt;
            preempt <= preempt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = cnt;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        busy_nxt    = busy;
        preempt_nxt = 1'b0;
        win         = pick(req, last);
        others      = req & ~(4'b0001 << last);

        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = 4'b0001 << win;
                    gnt_id_nxt = win;
                    busy_nxt   = 1'b1;
                    last_nxt   = win;
                    cnt_nxt    = '0;
                end else begin
                    gnt_nxt    = '0;
                    gnt_id_nxt = '0;
                    busy_nxt   = 1'b0;
                end
            end
            GRANT: begin
                // Owner dropping its request wins over a simultaneous hold-limit preemption.
                if (!req[last] || (cnt == HOLD_LAST && others != 4'b0000)) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    gnt_id_nxt  = '0;
                    busy_nxt    = 1'b0;
                    preempt_nxt = req[last];
                end else if (cnt != HOLD_LAST) begin
                    cnt_nxt = CNT_W'(cnt + CNT_W'(1));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: directed scenarios plus random traffic, all checked
// every cycle against an integer-level arbitration model.
module tb_rr_arb4;

    localparam int unsigned MH = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int n_tests;
    int n_fail;

    // Model: owner index (-1 none), last winner, cycles held so far.
    int m_owner;
    int m_last;
    int m_held;
    bit m_pre;

    rr_arb4 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r_rst, input logic [3:0] r_req);
        int others;
        m_pre = 1'b0;
        if (r_rst) begin
            m_owner = -1;
            m_last  = 3;
            m_held  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (m_last + k) % 4;
                if (m_owner < 0 && r_req[j]) m_owner = j;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 0;
            end
        end else begin
            others = 0;
            for (int j = 0; j < 4; j++)
                if (j != m_owner && r_req[j]) others = 1;
            if (!r_req[m_owner]) begin
                m_owner = -1;
            end else if (m_held == MH - 1 && others != 0) begin
                m_owner = -1;
                m_pre   = 1'b1;
            end else if (m_held < MH - 1) begin
                m_held = m_held + 1;
            end
        end
    endtask

    // Drive inputs, clock once, then compare everything against the model.
    task automatic step(input logic r_rst, input logic [3:0] r_req);
        logic [3:0] e_gnt;
        logic [1:0] e_id;
        logic [1:0] enc;
        rst = r_rst;
        req = r_req;
        @(posedge clk);
        #1;
        model_edge(r_rst, r_req);
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_id  = (m_owner < 0) ? 2'b00 : 2'(m_owner);
        chk("gnt", 8'(gnt), 8'(e_gnt));
        chk("gnt_id", 8'(gnt_id), 8'(e_id));
        chk("busy", 8'(busy), 8'(m_owner >= 0));
        chk("preempt", 8'(preempt), 8'(m_pre));
        case (gnt)
            4'b1000: enc = 2'b11;
            4'b0100: enc = 2'b10;
            4'b0010: enc = 2'b01;
            default: enc = 2'b00;
        endcase
        chk("onehot", 8'($countones(gnt) <= 1), 8'd1);
        chk("id_enc", 8'(gnt_id), 8'(enc));
    endtask

    initial begin
        logic [3:0] r;
        n_tests = 0;
        n_fail  = 0;
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_pre   = 1'b0;
        rst = 1'b1;
        req = 4'b0000;

        // Reset state
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);

        // Single request, grant one cycle later, release one cycle after drop
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0001);
        chk("s27_gnt", 8'(gnt), 8'h01);
        chk("s27_busy", 8'(busy), 8'h01);
        step(1'b0, 4'b0000);
        chk("s27_rel", 8'(gnt), 8'h00);

        // All requesting: rotate 0,1,2,3,0 with 8-cycle grants and a gap
        step(1'b1, 4'b0000);
        for (int t = 0; t < 45; t++) begin
            step(1'b0, 4'b1111);
            chk("s28_gnt", 8'(gnt), (t % 9 < 8) ? 8'(1 << ((t / 9) % 4)) : 8'h00);
            chk("s28_pre", 8'(preempt), 8'(t % 9 == 8));
        end

        // Sole requester keeps its grant indefinitely
        step(1'b1, 4'b0000);
        for (int t = 0; t < 20; t++) begin
            step(1'b0, 4'b1000);
            chk("s29_gnt", 8'(gnt), 8'h08);
            chk("s29_id", 8'(gnt_id), 8'h03);
            chk("s29_pre", 8'(preempt), 8'h00);
        end

        // Owner drop at hold limit beats preemption
        step(1'b1, 4'b0000);
        for (int t = 0; t < 10; t++) step(1'b0, 4'b0100);
        chk("s30_id", 8'(gnt_id), 8'h02);
        step(1'b0, 4'b0001);
        chk("s30_rel", 8'(gnt), 8'h00);
        chk("s30_pre", 8'(preempt), 8'h00);
        step(1'b0, 4'b0001);
        chk("s30_next", 8'(gnt), 8'h01);

        // Reset mid-grant, search restarts from index 0
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        for (int t = 0; t < 3; t++) step(1'b0, 4'b0011);
        step(1'b1, 4'b0011);
        chk("s31_rst", 8'(gnt), 8'h00);
        step(1'b0, 4'b1110);
        chk("s31_next", 8'(gnt), 8'h02);

        // Random traffic with sticky request patterns and occasional reset
        r = 4'b0000;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 79) == 0), r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
